// File: rtl/mem_arbiter_if.sv
// Requester A/B handshake plus memory pin bundle for the shared-memory arbiter.
interface mem_arbiter_if #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ADDR_SIZE = 16
);
    // Requester A
    logic                 a_req;
    logic                 a_we;
    logic [ADDR_SIZE-1:0] a_addr;
    logic [WORD_SIZE-1:0] a_wdata;
    logic                 a_ack;
    logic [WORD_SIZE-1:0] a_rdata;
    // Requester B
    logic                 b_req;
    logic                 b_we;
    logic [ADDR_SIZE-1:0] b_addr;
    logic [WORD_SIZE-1:0] b_wdata;
    logic                 b_ack;
    logic [WORD_SIZE-1:0] b_rdata;
    // Memory pins
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_data_in;
    logic                 mem_we;
    logic                 mem_oe;
    logic [WORD_SIZE-1:0] mem_data_out;
    // Status
    logic                 busy;
    logic                 grant_b;

    // Environment side: requesters and the memory's data_out
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_data_out,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  mem_addr, mem_data_in, mem_we, mem_oe,
        input  busy, grant_b
    );

    // Arbiter side
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_data_out,
        output a_ack, a_rdata, b_ack, b_rdata,
        output mem_addr, mem_data_in, mem_we, mem_oe,
        output busy, grant_b
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port memory.
// One access per IDLE -> ACCESS -> DONE pass; the winner gets a one-cycle ack in DONE.
module mem_arbiter #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned ADDR_SIZE = 16
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state_q;
    logic                 we_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic                 last_b_q;
    logic                 grant_b_q;
    logic                 a_ack_q;
    logic                 b_ack_q;
    logic [WORD_SIZE-1:0] a_rdata_q;
    logic [WORD_SIZE-1:0] b_rdata_q;
    logic                 mem_we_q;
    logic                 mem_oe_q;
    logic                 busy_q;

    logic                 win_b;
    logic                 sel_we;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [WORD_SIZE-1:0] sel_wdata;

    // Round-robin winner: a lone requester wins, a tie goes to whoever did not go last
    always_comb begin
        win_b     = bus.b_req & (~bus.a_req | ~last_b_q);
        sel_we    = win_b ? bus.b_we    : bus.a_we;
        sel_addr  = win_b ? bus.b_addr  : bus.a_addr;
        sel_wdata = win_b ? bus.b_wdata : bus.a_wdata;
    end

    // Sequencer: latch one request in IDLE, drive the pins for one cycle, ack in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            last_b_q  <= 1'b1;
            grant_b_q <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            mem_we_q  <= 1'b0;
            mem_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.a_req || bus.b_req) begin
                        grant_b_q <= win_b;
                        last_b_q  <= win_b;
                        we_q      <= sel_we;
                        addr_q    <= sel_addr;
                        wdata_q   <= sel_wdata;
                        mem_we_q  <= sel_we;
                        mem_oe_q  <= ~sel_we;
                        busy_q    <= 1'b1;
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we_q <= 1'b0;
                    mem_oe_q <= 1'b0;
                    if (grant_b_q) begin
                        b_ack_q <= 1'b1;
                        if (!we_q) begin
                            b_rdata_q <= bus.mem_data_out;
                        end
                    end else begin
                        a_ack_q <= 1'b1;
                        if (!we_q) begin
                            a_rdata_q <= bus.mem_data_out;
                        end
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    a_ack_q <= 1'b0;
                    b_ack_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Every output comes straight from a register
    assign bus.a_ack       = a_ack_q;
    assign bus.b_ack       = b_ack_q;
    assign bus.a_rdata     = a_rdata_q;
    assign bus.b_rdata     = b_rdata_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_data_in = wdata_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_oe      = mem_oe_q;
    assign bus.busy        = busy_q;
    assign bus.grant_b     = grant_b_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.WORD_SIZE(16), .ADDR_SIZE(16)) bus ();

    mem_arbiter #(.WORD_SIZE(16), .ADDR_SIZE(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory behind the arbiter; cleared by rst, write at posedge, async read.
    // Reads return 0 when oe is low (stands in for the floating bus).
    logic [15:0] tbmem [0:65535];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 65536; i++) tbmem[i] <= 16'h0000;
        end else if (bus.mem_we) begin
            tbmem[bus.mem_addr] <= bus.mem_data_in;
        end
    end
    assign bus.mem_data_out = bus.mem_oe ? tbmem[bus.mem_addr] : 16'h0000;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: each granted transaction is a record (grant cycle, owner,
    // op, addr, data). Its access occupies cycle g, its ack cycle g+1, and the
    // next grant can happen no earlier than the posedge opening cycle g+3.
    int          cyc     = 0;
    int          g       = -100;
    bit          started = 1'b0;
    bit          owner_b, last_b, t_we;
    logic [15:0] t_addr, t_wdata, rd_a, rd_b, rval;
    logic [15:0] mm [logic [15:0]];

    always @(posedge clk) begin : model
        cyc = cyc + 1;
        if (rst) begin
            started = 1'b1;
            g       = cyc - 2;
            owner_b = 1'b0;
            last_b  = 1'b1;
            t_we    = 1'b0;
            t_addr  = 16'h0;
            t_wdata = 16'h0;
            rd_a    = 16'h0;
            rd_b    = 16'h0;
            mm.delete();
        end else begin
            if (cyc == g + 1 && !t_we) begin
                if (owner_b) rd_b = rval;
                else         rd_a = rval;
            end
            if (cyc >= g + 3 && (bus.a_req || bus.b_req)) begin
                if (bus.a_req && bus.b_req) owner_b = !last_b;
                else                        owner_b = bus.b_req;
                last_b  = owner_b;
                g       = cyc;
                t_we    = owner_b ? bus.b_we    : bus.a_we;
                t_addr  = owner_b ? bus.b_addr  : bus.a_addr;
                t_wdata = owner_b ? bus.b_wdata : bus.a_wdata;
                if (t_we) mm[t_addr] = t_wdata;
                else      rval = mm.exists(t_addr) ? mm[t_addr] : 16'h0000;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, plus event counters
    int we_cnt = 0, a_acks = 0, b_acks = 0, both_acks = 0;
    bit ack_who [$];
    int ack_cyc [$];

    always @(negedge clk) begin : compare
        bit acc, dn;
        acc = (cyc == g);
        dn  = (cyc == g + 1);
        if (started) begin
            chk("busy",        32'(bus.busy),        32'(acc || dn));
            chk("mem_we",      32'(bus.mem_we),      32'(acc && t_we));
            chk("mem_oe",      32'(bus.mem_oe),      32'(acc && !t_we));
            chk("mem_addr",    32'(bus.mem_addr),    32'(t_addr));
            chk("mem_data_in", 32'(bus.mem_data_in), 32'(t_wdata));
            chk("grant_b",     32'(bus.grant_b),     32'(owner_b));
            chk("a_ack",       32'(bus.a_ack),       32'(dn && !owner_b));
            chk("b_ack",       32'(bus.b_ack),       32'(dn && owner_b));
            chk("a_rdata",     32'(bus.a_rdata),     32'(rd_a));
            chk("b_rdata",     32'(bus.b_rdata),     32'(rd_b));
        end
        if (bus.mem_we) we_cnt++;
        if (bus.a_ack) begin a_acks++; ack_who.push_back(1'b0); ack_cyc.push_back(cyc); end
        if (bus.b_ack) begin b_acks++; ack_who.push_back(1'b1); ack_cyc.push_back(cyc); end
        if (bus.a_ack && bus.b_ack) both_acks++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One isolated access from an idle arbiter, req dropped in the cycle after ack
    task automatic single(input bit pb, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, output logic [15:0] rd);
        if (pb) begin bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata; end
        else    begin bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata; end
        tick(1);
        chk("acc_mem_we",   32'(bus.mem_we),   32'(we));
        chk("acc_mem_oe",   32'(bus.mem_oe),   32'(!we));
        chk("acc_mem_addr", 32'(bus.mem_addr), 32'(addr));
        chk("acc_ack_early", 32'(pb ? bus.b_ack : bus.a_ack), 32'h0);
        tick(1);
        chk("done_ack",     32'(pb ? bus.b_ack : bus.a_ack), 32'h1);
        chk("done_other",   32'(pb ? bus.a_ack : bus.b_ack), 32'h0);
        chk("done_mem_we",  32'(bus.mem_we), 32'h0);
        rd = pb ? bus.b_rdata : bus.a_rdata;
        tick(1);
        if (pb) bus.b_req = 1'b0;
        else    bus.a_req = 1'b0;
        tick(1);
        chk("after_busy",   32'(bus.busy), 32'h0);
    endtask

    initial begin : stim
        logic [15:0] rd;
        int w0, b0, a0;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = 16'h0; bus.a_wdata = 16'h0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 16'h0; bus.b_wdata = 16'h0;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("rst_busy",    32'(bus.busy),    32'h0);
        chk("rst_grant_b", 32'(bus.grant_b), 32'h0);
        chk("rst_a_rdata", 32'(bus.a_rdata), 32'h0);
        chk("rst_b_ack",   32'(bus.b_ack),   32'h0);

        // A write 0x0010 = 0xBEEF: exactly one write strobe, no B ack
        w0 = we_cnt; b0 = b_acks;
        single(1'b0, 1'b1, 16'h0010, 16'hBEEF, rd);
        chk("wr_pulses", 32'(we_cnt - w0), 32'd1);
        chk("wr_no_back", 32'(b_acks - b0), 32'd0);

        // A reads it back; B's rdata untouched
        single(1'b0, 1'b0, 16'h0010, 16'h0000, rd);
        chk("rd_a_rdata", 32'(rd), 32'h0000BEEF);
        chk("rd_b_rdata", 32'(bus.b_rdata), 32'h0);

        // Continuous contention: A read 0x0001, B write 0x0002 = 0x1234
        ack_who.delete(); ack_cyc.delete(); both_acks = 0;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h0001;
        tick(1);
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 16'h0002; bus.b_wdata = 16'h1234;
        tick(11);
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        tick(3);
        chk("cont_acks", 32'(ack_who.size()), 32'd4);
        if (ack_who.size() >= 4) begin
            chk("cont_order0", 32'(ack_who[0]), 32'h0);
            chk("cont_order1", 32'(ack_who[1]), 32'h1);
            chk("cont_order2", 32'(ack_who[2]), 32'h0);
            chk("cont_order3", 32'(ack_who[3]), 32'h1);
            chk("cont_a_period", 32'(ack_cyc[2] - ack_cyc[0]), 32'd6);
            chk("cont_b_period", 32'(ack_cyc[3] - ack_cyc[1]), 32'd6);
        end
        chk("cont_both", 32'(both_acks), 32'd0);
        chk("cont_a_rdata", 32'(bus.a_rdata), 32'h0);

        // B write 0x0020 = 0x5555 with b_req held across DONE: two accesses
        w0 = we_cnt; b0 = b_acks;
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 16'h0020; bus.b_wdata = 16'h5555;
        tick(6);
        bus.b_req = 1'b0;
        tick(2);
        chk("hold_b_acks", 32'(b_acks - b0), 32'd2);
        chk("hold_writes", 32'(we_cnt - w0), 32'd2);
        w0 = we_cnt; b0 = b_acks;
        single(1'b1, 1'b1, 16'h0020, 16'h5555, rd);
        chk("drop_b_acks", 32'(b_acks - b0), 32'd1);
        chk("drop_writes", 32'(we_cnt - w0), 32'd1);

        // rst during A's read access: no ack, everything back to reset values
        a0 = a_acks;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 16'h0010;
        tick(1);
        chk("abort_in_access", 32'(bus.mem_oe), 32'h1);
        rst = 1'b1; bus.a_req = 1'b0;
        tick(1);
        chk("abort_busy",    32'(bus.busy),    32'h0);
        chk("abort_mem_we",  32'(bus.mem_we),  32'h0);
        chk("abort_mem_oe",  32'(bus.mem_oe),  32'h0);
        chk("abort_a_rdata", 32'(bus.a_rdata), 32'h0);
        rst = 1'b0;
        tick(3);
        chk("abort_no_ack", 32'(a_acks - a0), 32'd0);

        // Quiet arbiter for 10 cycles: pins idle, address parked at reset value
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("idle_busy",     32'(bus.busy),     32'h0);
            chk("idle_mem_we",   32'(bus.mem_we),   32'h0);
            chk("idle_mem_oe",   32'(bus.mem_oe),   32'h0);
            chk("idle_mem_addr", 32'(bus.mem_addr), 32'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
